fetch_controller: RTL and testbench
===================================

FETCH_CONTROLLER -- requirements
Module: fetch_controller

Interface
REQ-001 SHALL have parameter RESET_PC, default 64'd0, first fetch address loaded after reset.
REQ-002 SHALL have parameter TIMEOUT, default 16, maximum cycles an instruction-memory request may wait for imem_ready (legal range 2..255).
REQ-003 SHALL have port clk  input  1  system clock; all state changes on posedge.
REQ-004 SHALL have port reset  input  1  reset, synchronous, active-low (0 = reset).
REQ-005 SHALL have port pc_cur  input  64  current PC value from the program counter register.
REQ-006 SHALL have port hazard_stall  input  1  hazard unit requests fetch freeze.
REQ-007 SHALL have port branch_taken  input  1  redirect request, valid for one cycle.
REQ-008 SHALL have port branch_target  input  64  redirect address, sampled when branch_taken=1.
REQ-009 SHALL have port imem_ready  input  1  instruction memory response valid for the outstanding request.
REQ-010 SHALL have port pc_next  output  64  next-PC value driven to the program counter input.
REQ-011 SHALL have port pc_stall  output  1  1 = program counter holds; 0 = it loads pc_next.
REQ-012 SHALL have port imem_req  output  1  request to instruction memory, held until imem_ready.
REQ-013 SHALL have port imem_addr  output  64  registered request address.
REQ-014 SHALL have port if_valid  output  1  fetched instruction accepted into IF/ID this cycle.
REQ-015 SHALL have port if_flush  output  1  IF/ID flush pulse on redirect.
REQ-016 SHALL have port fetch_err  output  1  sticky memory-timeout error.

Function
REQ-017 SHALL implement states IDLE, FETCH, HOLD, DRAIN, ERROR.
REQ-018 IDLE: pc_next=RESET_PC, pc_stall=0, imem_req=0; next state FETCH unconditionally.
REQ-019 On every transition into FETCH, SHALL register imem_addr <= value the PC holds after that edge (RESET_PC from IDLE, pc_next from a PC-loading cycle, pc_cur otherwise).
REQ-020 FETCH: imem_req=1; pc_stall=1 while imem_ready=0.
REQ-021 FETCH, imem_ready=1, hazard_stall=0, branch_taken=0: if_valid=1, pc_stall=0, pc_next=pc_cur+4; stay FETCH (new request next cycle).
REQ-022 FETCH, imem_ready=1, hazard_stall=1, branch_taken=0: if_valid=0, pc_stall=1, response retained; next state HOLD.
REQ-023 HOLD: imem_req=0, pc_stall=1, if_valid=0 while hazard_stall=1; when hazard_stall=0: if_valid=1, pc_stall=0, pc_next=pc_cur+4, next state FETCH.
REQ-024 branch_taken=1 in FETCH or HOLD SHALL take priority over hazard_stall: pc_next=branch_target, pc_stall=0, if_flush=1, if_valid=0.
REQ-025 Redirect in HOLD or in FETCH with imem_ready=1: next state FETCH. Redirect in FETCH with imem_ready=0: next state DRAIN.
REQ-026 DRAIN: imem_req=1 (outstanding request kept), pc_stall=1, if_valid=0; response discarded on imem_ready=1, next state FETCH.
REQ-027 branch_taken in IDLE, DRAIN or ERROR SHALL be ignored.
REQ-028 pc_cur+4 SHALL wrap modulo 2^64; branch_target passed unmodified.
REQ-029 Wait counter SHALL clear on entry to FETCH/DRAIN and on imem_ready, increment each FETCH/DRAIN cycle with imem_ready=0; reaching TIMEOUT SHALL enter ERROR.
REQ-030 ERROR: fetch_err=1, pc_stall=1, imem_req=0, if_valid=0, if_flush=0; exit only by reset.
REQ-031 pc_next, pc_stall, if_valid, if_flush SHALL be combinational from state and inputs (zero-cycle latency); imem_req, imem_addr, fetch_err SHALL depend on state/registers only.
REQ-032 In states not driving pc_next explicitly, pc_next SHALL equal pc_cur.

Reset
REQ-033 reset=0 at posedge SHALL force state IDLE, wait counter 0, imem_addr=0, fetch_err=0, regardless of state (including mid-request or ERROR).
REQ-034 During reset cycle outputs SHALL be IDLE values: pc_stall=0, pc_next=RESET_PC, imem_req=0, if_valid=0, if_flush=0.

Verification
REQ-035 Reset release, imem_ready=1 every FETCH cycle -> imem_addr sequence 0,4,8,12; if_valid high one cycle per fetch.
REQ-036 imem_ready at PC=0x10 with hazard_stall=1 for 3 cycles -> HOLD 3 cycles, pc_stall=1, then if_valid=1, pc_next=0x14.
REQ-037 branch_taken, target 0x200, in FETCH with imem_ready=0 -> if_flush=1, pc_next=0x200 same cycle; DRAIN until imem_ready; next imem_addr=0x200, discarded response never raises if_valid.
REQ-038 branch_taken and hazard_stall both 1 in HOLD -> redirect wins, if_flush=1, next state FETCH.
REQ-039 TIMEOUT=4, imem_ready held 0 -> ERROR after 4 FETCH cycles, fetch_err=1 sticky; reset=0 clears to IDLE.
REQ-040 pc_cur=0xFFFF_FFFF_FFFF_FFFC, imem_ready=1 -> pc_next=0.

Source files
------------

// File: rtl/fetch_controller.sv
// fetch_controller: instruction-fetch sequencer. Issues one instruction-memory
// request at a time, steers the next PC (sequential, redirect or hold), parks
// a response while the hazard unit freezes the pipe, drains a request that
// was orphaned by a redirect, and latches a sticky error on memory timeout.
module fetch_controller #(
    parameter logic [63:0] RESET_PC = 64'd0,
    parameter int unsigned TIMEOUT  = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [63:0] pc_cur,
    input  logic        hazard_stall,
    input  logic        branch_taken,
    input  logic [63:0] branch_target,
    input  logic        imem_ready,
    output logic [63:0] pc_next,
    output logic        pc_stall,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    output logic        if_valid,
    output logic        if_flush,
    output logic        fetch_err
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        HOLD  = 3'd2,
        DRAIN = 3'd3,
        ERROR = 3'd4
    } state_t;

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    state_t      state_q, state_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;
    logic [63:0] imem_addr_q, imem_addr_d;
    logic        fetch_err_q, fetch_err_d;

    logic [63:0] pc_inc;
    logic        timeout_hit;
    logic        waiting;
    logic        new_req;

    // Sequential PC wraps naturally at 2^64.
    assign pc_inc      = pc_cur + 64'd4;
    // Current unanswered cycle would be the TIMEOUT-th one.
    assign timeout_hit = (wait_cnt_q + 8'd1) == TIMEOUT_CNT;
    assign waiting     = (state_q == FETCH) || (state_q == DRAIN);

    // Next state plus the zero-latency PC/pipeline handshake outputs.
    always_comb begin
        state_d  = state_q;
        pc_next  = pc_cur;
        pc_stall = 1'b1;
        if_valid = 1'b0;
        if_flush = 1'b0;

        case (state_q)
            IDLE: begin
                pc_next  = RESET_PC;
                pc_stall = 1'b0;
                state_d  = FETCH;
            end
            FETCH: begin
                if (branch_taken) begin
                    // Redirect beats hazard; an unanswered request must drain.
                    pc_next  = branch_target;
                    pc_stall = 1'b0;
                    if_flush = 1'b1;
                    state_d  = imem_ready ? FETCH : DRAIN;
                end else if (imem_ready) begin
                    if (hazard_stall) begin
                        state_d = HOLD;
                    end else begin
                        if_valid = 1'b1;
                        pc_stall = 1'b0;
                        pc_next  = pc_inc;
                    end
                end else if (timeout_hit) begin
                    state_d = ERROR;
                end
            end
            HOLD: begin
                if (branch_taken) begin
                    pc_next  = branch_target;
                    pc_stall = 1'b0;
                    if_flush = 1'b1;
                    state_d  = FETCH;
                end else if (!hazard_stall) begin
                    if_valid = 1'b1;
                    pc_stall = 1'b0;
                    pc_next  = pc_inc;
                    state_d  = FETCH;
                end
            end
            DRAIN: begin
                // Stale response is swallowed; PC already holds the target.
                if (imem_ready) begin
                    state_d = FETCH;
                end else if (timeout_hit) begin
                    state_d = ERROR;
                end
            end
            ERROR: begin
                state_d = ERROR;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Reset cycle presents the IDLE face regardless of the current state.
        if (!reset) begin
            state_d  = IDLE;
            pc_next  = RESET_PC;
            pc_stall = 1'b0;
            if_valid = 1'b0;
            if_flush = 1'b0;
        end
    end

    // Request address, wait counter and sticky error next-state.
    always_comb begin
        // A new request starts on entry to FETCH, or when FETCH gets its answer.
        new_req     = (state_d == FETCH) && ((state_q != FETCH) || imem_ready);
        imem_addr_d = imem_addr_q;
        if (new_req) begin
            // Address the PC will hold after this edge.
            imem_addr_d = pc_stall ? pc_cur : pc_next;
        end

        wait_cnt_d = 8'd0;
        if (waiting && !imem_ready && (state_d == state_q)) begin
            wait_cnt_d = wait_cnt_q + 8'd1;
        end

        fetch_err_d = fetch_err_q || (state_d == ERROR);
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            wait_cnt_q  <= 8'd0;
            imem_addr_q <= 64'd0;
            fetch_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            imem_addr_q <= imem_addr_d;
            fetch_err_q <= fetch_err_d;
        end
    end

    assign imem_req  = (state_q == FETCH) || (state_q == DRAIN);
    assign imem_addr = imem_addr_q;
    assign fetch_err = fetch_err_q;

endmodule

// File: tb/tb_fetch_controller.sv
// tb_fetch_controller: drives fetch_controller with an external PC register,
// checks handshake outputs directly and fetched addresses via a scoreboard.
module tb_fetch_controller;

    localparam logic [63:0] RPC = 64'd0;
    localparam logic [63:0] TOP = 64'hFFFF_FFFF_FFFF_FFFC;

    logic        clk;
    logic        reset;
    logic [63:0] pc_cur;
    logic        hazard_stall;
    logic        branch_taken;
    logic [63:0] branch_target;
    logic        imem_ready;
    logic [63:0] pc_next;
    logic        pc_stall;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        if_valid;
    logic        if_flush;
    logic        fetch_err;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [63:0] exp_q[$];

    fetch_controller #(.RESET_PC(RPC), .TIMEOUT(4)) dut (
        .clk           (clk),
        .reset         (reset),
        .pc_cur        (pc_cur),
        .hazard_stall  (hazard_stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .imem_ready    (imem_ready),
        .pc_next       (pc_next),
        .pc_stall      (pc_stall),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .if_valid      (if_valid),
        .if_flush      (if_flush),
        .fetch_err     (fetch_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Program counter register owned by the environment.
    initial pc_cur = 64'h1234;
    always @(posedge clk) begin
        if (!pc_stall) pc_cur <= pc_next;
    end

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rdy, input logic hz, input logic br, input logic [63:0] tgt);
        imem_ready    = rdy;
        hazard_stall  = hz;
        branch_taken  = br;
        branch_target = tgt;
        #1;
    endtask

    // Scoreboard: every accepted fetch must match the next expected address.
    always @(negedge clk) begin
        if (reset === 1'b1 && if_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("sb_unexpected_fetch", imem_addr, 64'hDEAD_BEEF_DEAD_BEEF);
            end else begin
                chk("sb_fetch_addr", imem_addr, exp_q.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not end, n_checks %0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 64'd0);
        tick();
        drive(1'b1, 1'b1, 1'b1, 64'h40);
        chk("rst_imem_req", 64'(imem_req), 64'd0);
        chk("rst_imem_addr", imem_addr, 64'd0);
        chk("rst_fetch_err", 64'(fetch_err), 64'd0);
        chk("rst_pc_next", pc_next, RPC);
        chk("rst_pc_stall", 64'(pc_stall), 64'd0);
        chk("rst_if_valid", 64'(if_valid), 64'd0);
        chk("rst_if_flush", 64'(if_flush), 64'd0);
        tick();

        // Leave reset: one IDLE cycle, then sequential fetch.
        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 64'd0);
        chk("idle_pc_next", pc_next, RPC);
        chk("idle_pc_stall", 64'(pc_stall), 64'd0);
        tick();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, 1'b0, 64'd0);
            exp_q.push_back(64'(i * 4));
            chk("seq_imem_req", 64'(imem_req), 64'd1);
            chk("seq_if_valid", 64'(if_valid), 64'd1);
            chk("seq_pc_next", pc_next, 64'(i * 4 + 4));
            tick();
        end

        // Hazard while a response arrives at 0x10.
        drive(1'b1, 1'b1, 1'b0, 64'd0);
        chk("hz_if_valid", 64'(if_valid), 64'd0);
        chk("hz_pc_stall", 64'(pc_stall), 64'd1);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, 1'b0, 64'd0);
            chk("hold_imem_req", 64'(imem_req), 64'd0);
            chk("hold_pc_stall", 64'(pc_stall), 64'd1);
            chk("hold_if_valid", 64'(if_valid), 64'd0);
            tick();
        end
        drive(1'b0, 1'b0, 1'b0, 64'd0);
        exp_q.push_back(64'h10);
        chk("hold_rel_if_valid", 64'(if_valid), 64'd1);
        chk("hold_rel_pc_stall", 64'(pc_stall), 64'd0);
        chk("hold_rel_pc_next", pc_next, 64'h14);
        tick();
        chk("hold_next_addr", imem_addr, 64'h14);

        // Redirect with the request still outstanding: drain it.
        drive(1'b0, 1'b0, 1'b1, 64'h200);
        chk("br_if_flush", 64'(if_flush), 64'd1);
        chk("br_pc_next", pc_next, 64'h200);
        chk("br_pc_stall", 64'(pc_stall), 64'd0);
        chk("br_if_valid", 64'(if_valid), 64'd0);
        tick();
        drive(1'b0, 1'b0, 1'b0, 64'd0);
        chk("drain_imem_req", 64'(imem_req), 64'd1);
        chk("drain_pc_stall", 64'(pc_stall), 64'd1);
        tick();
        drive(1'b1, 1'b0, 1'b0, 64'd0);
        chk("drain_discard_valid", 64'(if_valid), 64'd0);
        chk("drain_discard_stall", 64'(pc_stall), 64'd1);
        tick();
        chk("drain_next_addr", imem_addr, 64'h200);

        // Redirect and hazard together in HOLD.
        drive(1'b1, 1'b1, 1'b0, 64'd0);
        tick();
        drive(1'b0, 1'b1, 1'b1, 64'h300);
        chk("hb_if_flush", 64'(if_flush), 64'd1);
        chk("hb_pc_next", pc_next, 64'h300);
        chk("hb_pc_stall", 64'(pc_stall), 64'd0);
        chk("hb_if_valid", 64'(if_valid), 64'd0);
        tick();
        chk("hb_imem_req", 64'(imem_req), 64'd1);
        chk("hb_imem_addr", imem_addr, 64'h300);

        // Redirect with response present, then wrap at the top of memory.
        drive(1'b1, 1'b0, 1'b1, TOP);
        chk("br_rdy_if_flush", 64'(if_flush), 64'd1);
        chk("br_rdy_if_valid", 64'(if_valid), 64'd0);
        tick();
        chk("wrap_addr", imem_addr, TOP);
        drive(1'b1, 1'b0, 1'b0, 64'd0);
        exp_q.push_back(TOP);
        chk("wrap_pc_next", pc_next, 64'd0);
        chk("wrap_if_valid", 64'(if_valid), 64'd1);
        tick();
        chk("wrap_next_addr", imem_addr, 64'd0);

        // Memory never answers: timeout after four FETCH cycles.
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b0, 1'b0, 64'd0);
            chk("to_fetch_err_low", 64'(fetch_err), 64'd0);
            chk("to_imem_req", 64'(imem_req), 64'd1);
            chk("to_pc_stall", 64'(pc_stall), 64'd1);
            tick();
        end
        chk("err_fetch_err", 64'(fetch_err), 64'd1);
        chk("err_imem_req", 64'(imem_req), 64'd0);
        drive(1'b1, 1'b0, 1'b1, 64'h500);
        chk("err_br_if_flush", 64'(if_flush), 64'd0);
        chk("err_br_pc_stall", 64'(pc_stall), 64'd1);
        chk("err_br_pc_next", pc_next, 64'd0);
        chk("err_if_valid", 64'(if_valid), 64'd0);
        tick();
        tick();
        chk("err_sticky", 64'(fetch_err), 64'd1);

        // Reset out of ERROR.
        reset = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 64'd0);
        chk("rst_err_pc_stall", 64'(pc_stall), 64'd0);
        chk("rst_err_pc_next", pc_next, RPC);
        tick();
        chk("rst_err_fetch_err", 64'(fetch_err), 64'd0);
        chk("rst_err_imem_req", 64'(imem_req), 64'd0);
        chk("rst_err_imem_addr", imem_addr, 64'd0);
        reset = 1'b1;
        tick();
        drive(1'b1, 1'b0, 1'b0, 64'd0);
        exp_q.push_back(RPC);
        chk("post_rst_if_valid", 64'(if_valid), 64'd1);
        tick();
        drive(1'b0, 1'b0, 1'b0, 64'd0);
        #10;
        chk("sb_empty", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
